// File: rtl/prio_arb_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prio_arb_rr
// Brief    : Registered N-input priority/round-robin arbiter with one-hot
//            grant and VALID/READY output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module prio_arb_rr #(
    parameter int N = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         A,
    input  logic                 RR_EN,
    input  logic                 READY,
    output logic                 VALID,
    output logic [$clog2(N)-1:0] Y,
    output logic [N-1:0]         GRANT
);

    localparam int W = $clog2(N);

    logic         r_valid;
    logic [W-1:0] r_y;
    logic [W-1:0] r_last;

    logic         w_ld;
    logic         w_any;
    logic [W-1:0] w_fix_idx;
    logic [W-1:0] w_rr_idx;
    logic         w_rr_hit;
    logic [W-1:0] w_cand;
    logic [W-1:0] w_win;
    logic [N-1:0] w_grant;

    assign w_ld  = !r_valid || READY;
    assign w_any = |A;

    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (A[W'(i)]) begin
                w_fix_idx = W'(i);
            end
        end
    end

    // Round-robin search LAST-1 downwards, wrapping modulo N, LAST checked last.
    always_comb begin
        w_rr_idx = '0;
        w_rr_hit = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = W'((int'(r_last) + N - k) % N);
            if (!w_rr_hit && A[w_cand]) begin
                w_rr_idx = w_cand;
                w_rr_hit = 1'b1;
            end
        end
    end

    assign w_win = RR_EN ? w_rr_idx : w_fix_idx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_last  <= '0;
        end else if (w_ld) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_y     <= w_win;
                r_last  <= w_win;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (r_valid) begin
            w_grant[r_y] = 1'b1;
        end
    end

    assign VALID = r_valid;
    assign Y     = r_y;
    assign GRANT = w_grant;

endmodule
`default_nettype wire

// File: doc/prio_arb_rr.md
Name: prio_arb_rr

Overview:
- Parametrised, registered N-input priority encoder and arbiter; next generation of the team's 8-to-3 combinational priority encoder.
- Adds a selectable round-robin mode, a one-hot grant output and a VALID/READY output handshake with backpressure.
- Sits between request sources and a single shared consumer (bus or port); one grant is issued per accepted transfer.

Parameters:
- N, 8, number of request inputs (N >= 2; need not be a power of 2).
- W, $clog2(N), index width (derived localparam; not overridable).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  N  request vector; bit i = requester i.
- RR_EN  input  1  0 = fixed priority, 1 = round-robin.
- READY  input  1  consumer accepts the current grant.
- VALID  output  1  Y/GRANT hold a valid grant.
- Y  output  W  binary index of the granted requester.
- GRANT  output  N  one-hot of Y when VALID=1, else all zero.

Behaviour:
- Reset (async, immediate): VALID=0, Y=0, GRANT=0, internal LAST=0. Applies mid-transfer too; any pending grant is dropped.
- Load condition LD = !VALID || READY. A is sampled only on a rising CLK edge with LD=1.
- Latency: exactly 1 cycle from sample edge to VALID/Y update.
- On LD with A != 0: VALID<=1, Y<=winner, LAST<=winner.
- On LD with A == 0: VALID<=0, Y holds its previous value, LAST holds.
- VALID=1 && READY=0: Y, GRANT and VALID stay stable; changes on A are ignored (no retraction, no re-arbitration).
- VALID=1 && READY=1: transfer completes; A is sampled in the same edge. Back-to-back grants every cycle are supported.
- Fixed priority (RR_EN=0): winner = highest set index of A (bit N-1 highest). LAST is still updated but not used.
- Round-robin (RR_EN=1): search order is LAST-1, LAST-2, ... down to 0, then wrap to N-1 ... LAST. Winner = first set bit in that order. LAST itself is the lowest priority.
  - Wrap uses modulo N, not 2^W. For N=5 with LAST=0, the next candidate is 4, never 7.
  - After reset (LAST=0) the order is N-1..0, identical to fixed mode.
- RR_EN may change on any cycle; it takes effect at the next load. LAST is preserved across mode changes.
- Y never exceeds N-1. GRANT is a combinational decode of the VALID and Y registers.

Test Plan:
- Reset, N=8: RST pulse while VALID=1 -> VALID=0, Y=0, GRANT=0 immediately (no CLK edge needed); first RR grant with A=8'hFF -> Y=7.
- Fixed mode: N=8, RR_EN=0, A=8'b1000_0001 held, READY=1 -> Y=7 every cycle, GRANT=8'h80; then A=8'h06 -> next cycle Y=2, GRANT=8'h04.
- Round-robin: N=8, RR_EN=1, A=8'b1000_0001 held, READY=1 -> Y sequence 7,0,7,0; A=8'hFF -> 7,6,5,...,0,7.
- Backpressure: VALID=1, Y=5, READY=0 for 4 cycles while A changes to 8'h80 -> Y stays 5, VALID stays 1; READY=1 -> Y=7 next cycle.
- Empty: A=0 with READY=1 -> VALID=0 next cycle, Y unchanged, GRANT=0; A=8'h10 -> VALID=1, Y=4 one cycle later.
- Non-power-of-2 wrap: N=5, RR_EN=1, A=5'b10001, READY=1 -> Y alternates 4,0. Y is never 5-7 under random A (checker assertion).
